// File: rtl/pool2x2_nibble_server_pkg.sv
// Shared definitions for the 2x2 nibble pooling server and the conv engines that talk to it.
package pool2x2_nibble_server_pkg;

   localparam int unsigned NIB_W         = 4;
   localparam int unsigned NIBS_PER_WORD = 8;
   localparam int unsigned WORD_W        = NIB_W * NIBS_PER_WORD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CAPTURE,
      ST_WRITE,
      ST_DONE
   } pool_state_t;

   typedef struct packed {
      logic [28:0] word_idx;
      logic [2:0]  nib_sel;
   } nib_addr_t;

   // Nibble address -> (packed word index, nibble select); nibble 0 is the MSB nibble.
   function automatic nib_addr_t split_nib_addr(input logic [31:0] addr);
      nib_addr_t s;
      s.word_idx = addr[31:3];
      s.nib_sel  = addr[2:0];
      return s;
   endfunction

   function automatic logic [NIB_W-1:0] get_nib(input logic [WORD_W-1:0] w,
                                                 input logic [2:0]        sel);
      return NIB_W'(w >> {3'd7 - sel, 2'b00});
   endfunction

endpackage

// File: rtl/pool_reduce8.sv
// Combinational 2x2 reducer: A0/A1 (upper row) and B0/B1 (lower row) source words -> one pooled word.
// Defining POOL_AVG_EN selects the rounded 4-input average instead of the unsigned max.
module pool_reduce8
   import pool2x2_nibble_server_pkg::*;
(
   input  logic [WORD_W-1:0] i_a0,
   input  logic [WORD_W-1:0] i_a1,
   input  logic [WORD_W-1:0] i_b0,
   input  logic [WORD_W-1:0] i_b1,
   output logic [WORD_W-1:0] o_word
);

   function automatic logic [NIB_W-1:0] reduce4(input logic [NIB_W-1:0] a,
                                                 input logic [NIB_W-1:0] b,
                                                 input logic [NIB_W-1:0] c,
                                                 input logic [NIB_W-1:0] d);
`ifdef POOL_AVG_EN
      return NIB_W'((6'(a) + 6'(b) + 6'(c) + 6'(d) + 6'd2) >> 2);
`else
      logic [NIB_W-1:0] m0;
      logic [NIB_W-1:0] m1;
      m0 = (a > b) ? a : b;
      m1 = (c > d) ? c : d;
      return (m0 > m1) ? m0 : m1;
`endif
   endfunction

   logic [WORD_W-1:0] w_a;
   logic [WORD_W-1:0] w_b;
   logic [2:0]        w_s0;
   logic [2:0]        w_s1;

   // Output nibbles are shifted in from the LSB so nibble 0 lands in the MSB position.
   always_comb begin
      o_word = '0;
      w_a    = '0;
      w_b    = '0;
      w_s0   = '0;
      w_s1   = '0;
      for (int unsigned j = 0; j < NIBS_PER_WORD; j++) begin
         w_a    = (j < 4) ? i_a0 : i_a1;
         w_b    = (j < 4) ? i_b0 : i_b1;
         w_s0   = 3'((j % 4) * 2);
         w_s1   = 3'((j % 4) * 2 + 1);
         o_word = {o_word[WORD_W-NIB_W-1:0],
                   reduce4(get_nib(w_a, w_s0), get_nib(w_a, w_s1),
                           get_nib(w_b, w_s0), get_nib(w_b, w_s1))};
      end
   end

endmodule

// File: rtl/pool2x2_nibble_server.sv
// 2x2/stride-2 pooling of a packed 4-bit activation map into an internal buffer, served by nibble reads.
// Build option POOL_AVG_EN: rounded-average pooling instead of max (same latency and interface).
module pool2x2_nibble_server
   import pool2x2_nibble_server_pkg::*;
#(
   parameter int unsigned CHANNELS = 32,
   parameter int unsigned IN_DIM   = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              pool_start,
   output logic              pool_done,
   output logic              pool_busy,
   input  logic [31:0]       pool_read_addr,
   output logic [NIB_W-1:0]  pool_read_data,
   output logic [11:0]       src_addr,
   output logic              src_en,
   input  logic [WORD_W-1:0] src_data
);

   localparam int unsigned OUT_DIM   = IN_DIM / 2;
   localparam int unsigned HBLKS     = OUT_DIM / 8;
   localparam int unsigned IN_WPR    = IN_DIM / 8;
   localparam int unsigned IN_WPC    = IN_DIM * IN_DIM / 8;
   localparam int unsigned BUF_WORDS = CHANNELS * OUT_DIM * OUT_DIM / 8;
   localparam int unsigned WORD_AW   = $clog2(BUF_WORDS);
   localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned R_W       = $clog2(OUT_DIM);
   localparam int unsigned H_W       = (HBLKS > 1) ? $clog2(HBLKS) : 1;

   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
   localparam logic [R_W-1:0]  R_LAST  = R_W'(OUT_DIM - 1);
   localparam logic [H_W-1:0]  H_LAST  = H_W'(HBLKS - 1);

   pool_state_t r_state;
   pool_state_t w_next;

   logic [CH_W-1:0]   r_ch;
   logic [R_W-1:0]    r_r;
   logic [H_W-1:0]    r_h;
   logic [1:0]        r_k;
   logic [WORD_W-1:0] r_a0;
   logic [WORD_W-1:0] r_a1;
   logic [WORD_W-1:0] r_b0;
   logic [WORD_W-1:0] r_b1;
   logic [WORD_W-1:0] r_buf [BUF_WORDS];
   logic [NIB_W-1:0]  r_rdata;

   logic               w_last;
   logic [11:0]        w_src_addr;
   logic [WORD_AW-1:0] w_wr_idx;
   logic [WORD_W-1:0]  w_pooled;
   nib_addr_t          w_rd;
   logic               w_rd_oob;

   assign w_last = (r_h == H_LAST) && (r_r == R_LAST) && (r_ch == CH_LAST);

   // Fetch order k = 0..3 is A0, A1, B0, B1: k[1] picks the row, k[0] the word-column.
   assign w_src_addr = 12'(r_ch) * 12'(IN_WPC)
                     + 12'({r_r, r_k[1]}) * 12'(IN_WPR)
                     + 12'({r_h, r_k[0]});

   assign w_wr_idx = WORD_AW'(r_ch) * WORD_AW'(HBLKS * OUT_DIM)
                   + WORD_AW'(r_r) * WORD_AW'(HBLKS)
                   + WORD_AW'(r_h);

   pool_reduce8 u_reduce (
      .i_a0   (r_a0),
      .i_a1   (r_a1),
      .i_b0   (r_b0),
      .i_b1   (r_b1),
      .o_word (w_pooled)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:    if (pool_start) w_next = ST_FETCH;
         ST_FETCH:   if (r_k == 2'd3) w_next = ST_CAPTURE;
         ST_CAPTURE: w_next = ST_WRITE;
         ST_WRITE:   w_next = w_last ? ST_DONE : ST_FETCH;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      src_en    = (r_state == ST_FETCH);
      src_addr  = (r_state == ST_FETCH) ? w_src_addr : '0;
      pool_done = (r_state == ST_DONE);
      pool_busy = (r_state != ST_IDLE);
   end

   // Each FETCH cycle captures the word requested one cycle earlier; CAPTURE takes the last one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ch <= '0;
         r_r  <= '0;
         r_h  <= '0;
         r_k  <= '0;
         r_a0 <= '0;
         r_a1 <= '0;
         r_b0 <= '0;
         r_b1 <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ch <= '0;
               r_r  <= '0;
               r_h  <= '0;
               r_k  <= '0;
            end
            ST_FETCH: begin
               r_k <= r_k + 2'd1;
               case (r_k)
                  2'd1:    r_a0 <= src_data;
                  2'd2:    r_a1 <= src_data;
                  2'd3:    r_b0 <= src_data;
                  default: ;
               endcase
            end
            ST_CAPTURE: r_b1 <= src_data;
            ST_WRITE: begin
               if (r_h == H_LAST) begin
                  r_h <= '0;
                  if (r_r == R_LAST) begin
                     r_r  <= '0;
                     r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                  end else begin
                     r_r <= r_r + 1'b1;
                  end
               end else begin
                  r_h <= r_h + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_WRITE) r_buf[w_wr_idx] <= w_pooled;
   end

   // Read port runs independently of the FSM; addresses past the buffer read as zero.
   assign w_rd     = split_nib_addr(pool_read_addr);
   assign w_rd_oob = |w_rd.word_idx[28:WORD_AW];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rdata <= '0;
      else       r_rdata <= w_rd_oob ? '0
                            : get_nib(r_buf[w_rd.word_idx[WORD_AW-1:0]], w_rd.nib_sel);
   end

   assign pool_read_data = r_rdata;

endmodule

// File: tb/tb_pool2x2_nibble_server.sv
// Bench for pool2x2_nibble_server: source MRAM model, directed pooling runs, scoreboarded read sweeps.
module tb_pool2x2_nibble_server;

   localparam int unsigned CHANNELS   = 32;
   localparam int unsigned IN_DIM     = 32;
   localparam int unsigned OUT_DIM    = IN_DIM / 2;
   localparam int unsigned SRC_WORDS  = CHANNELS * IN_DIM * IN_DIM / 8;
   localparam int unsigned SRC_AW     = $clog2(SRC_WORDS);
   localparam int unsigned N_NIBS     = CHANNELS * OUT_DIM * OUT_DIM;
   localparam int unsigned RUN_CYCLES = (N_NIBS / 8) * 6 + 2;
   localparam int unsigned PAT_RAMP   = 0;
   localparam int unsigned PAT_WINDOW = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        pool_start;
   logic        pool_done;
   logic        pool_busy;
   logic [31:0] pool_read_addr;
   logic [3:0]  pool_read_data;
   logic [11:0] src_addr;
   logic        src_en;
   logic [31:0] src_data = '0;

   logic [31:0] src_mem [SRC_WORDS];
   logic [31:0] src_next = '0;
   logic [3:0]  exp_q [$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   pool2x2_nibble_server #(.CHANNELS(CHANNELS), .IN_DIM(IN_DIM)) dut (
      .clk            (clk),
      .reset          (reset),
      .pool_start     (pool_start),
      .pool_done      (pool_done),
      .pool_busy      (pool_busy),
      .pool_read_addr (pool_read_addr),
      .pool_read_data (pool_read_data),
      .src_addr       (src_addr),
      .src_en         (src_en),
      .src_data       (src_data)
   );

   always #5 clk = ~clk;

   // Source MRAM: a request seen in one cycle returns its word throughout the next cycle.
   always @(negedge clk) if (src_en) src_next = src_mem[src_addr];
   always @(posedge clk) begin
      #1;
      src_data = src_next;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [3:0] gen_nib(input int unsigned pat, input int unsigned ch,
                                          input int unsigned y, input int unsigned x);
      if (pat == PAT_RAMP) return 4'((x + y) & 15);
      return ((((y % 2) * 2 + (x % 2)) == ((ch + y / 2 + x / 2) % 4)) ? 4'h0 : 4'hF);
   endfunction

   function automatic logic [3:0] exp_pool(input int unsigned pat, input int unsigned addr);
      int unsigned ch, r, col;
      logic [3:0] a, b, c, d, m0, m1;
      ch  = addr / (OUT_DIM * OUT_DIM);
      r   = (addr / OUT_DIM) % OUT_DIM;
      col = addr % OUT_DIM;
      a = gen_nib(pat, ch, 2 * r,     2 * col);
      b = gen_nib(pat, ch, 2 * r,     2 * col + 1);
      c = gen_nib(pat, ch, 2 * r + 1, 2 * col);
      d = gen_nib(pat, ch, 2 * r + 1, 2 * col + 1);
`ifdef POOL_AVG_EN
      m0 = '0;
      m1 = '0;
      return 4'((6'(a) + 6'(b) + 6'(c) + 6'(d) + 6'd2) >> 2);
`else
      m0 = (a > b) ? a : b;
      m1 = (c > d) ? c : d;
      return (m0 > m1) ? m0 : m1;
`endif
   endfunction

   task automatic fill_mem(input int unsigned pat);
      logic [31:0] word;
      for (int unsigned ch = 0; ch < CHANNELS; ch++)
         for (int unsigned y = 0; y < IN_DIM; y++)
            for (int unsigned xw = 0; xw < IN_DIM / 8; xw++) begin
               word = '0;
               for (int unsigned n = 0; n < 8; n++)
                  word = {word[27:0], gen_nib(pat, ch, y, xw * 8 + n)};
               src_mem[SRC_AW'(ch * (IN_DIM * IN_DIM / 8) + y * (IN_DIM / 8) + xw)] = word;
            end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_done"},  32'(pool_done),      32'd0);
      check({tag, "_busy"},  32'(pool_busy),      32'd0);
      check({tag, "_src_en"}, 32'(src_en),        32'd0);
      check({tag, "_src_addr"}, 32'(src_addr),    32'd0);
      check({tag, "_rdata"}, 32'(pool_read_data), 32'd0);
   endtask

   // Cycle 1 is the cycle pool_start is high; pool_done is due in cycle RUN_CYCLES.
   task automatic run_pool(input int unsigned restart_at, input bit start_in_done, input string tag);
      int unsigned done_cnt, first_done, busy_cnt, busy_after;
      done_cnt = 0; first_done = 0; busy_cnt = 0; busy_after = 0;
      check({tag, "_busy_before_start"}, 32'(pool_busy), 32'd0);
      pool_start = 1'b1;
      @(posedge clk); #1;
      pool_start = 1'b0;
      for (int unsigned cyc = 2; cyc <= RUN_CYCLES + 40; cyc++) begin
         if (cyc <= 5) begin
            check({tag, "_src_en"}, 32'(src_en), 32'd1);
            check({tag, "_src_addr"}, 32'(src_addr),
                  32'(((cyc - 2) / 2) * (IN_DIM / 8) + (cyc - 2) % 2));
         end
         if (pool_done) begin
            done_cnt++;
            if (first_done == 0) first_done = cyc;
         end
         if (pool_busy) begin
            if (first_done == 0 || cyc == first_done) busy_cnt++;
            else busy_after++;
         end
         pool_start = (cyc == restart_at) || (start_in_done && pool_done);
         @(posedge clk); #1;
      end
      pool_start = 1'b0;
      check({tag, "_done_cycle"}, first_done, RUN_CYCLES);
      check({tag, "_done_count"}, done_cnt, 32'd1);
      check({tag, "_busy_cycles"}, busy_cnt, RUN_CYCLES - 1);
      check({tag, "_busy_after_done"}, busy_after, 32'd0);
   endtask

   task automatic sweep(input int unsigned pat, input string tag);
      logic [3:0] e;
      for (int unsigned a = 0; a < N_NIBS; a++) begin
         pool_read_addr = a;
         exp_q.push_back(exp_pool(pat, a));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         check(tag, 32'(pool_read_data), 32'(e));
      end
   endtask

   task automatic run_with_reset(input int unsigned reset_at);
      int unsigned stray;
      stray = 0;
      pool_read_addr = 32'd17;
      pool_start = 1'b1;
      @(posedge clk); #1;
      pool_start = 1'b0;
      for (int unsigned cyc = 2; cyc < reset_at; cyc++) begin
         @(posedge clk); #1;
      end
      check("mid_run_busy", 32'(pool_busy), 32'd1);
      // word 2 was rewritten with ramp data early in this run
      check("mid_run_rdata", 32'(pool_read_data), 32'(exp_pool(PAT_RAMP, 17)));
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (pool_busy || pool_done) stray++;
         @(posedge clk); #1;
      end
      check("reset_dropped_run", stray, 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      pool_start     = 1'b0;
      pool_read_addr = '0;
      fill_mem(PAT_RAMP);
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      run_pool(0, 1'b0, "ramp");
      sweep(PAT_RAMP, "ramp_read");
      // rows 2-3, cols 2-3 of ch 0 hold 4,5,5,6
      pool_read_addr = 32'd17;
      @(posedge clk); #1;
`ifdef POOL_AVG_EN
      check("ramp_addr17", 32'(pool_read_data), 32'd5);
`else
      check("ramp_addr17", 32'(pool_read_data), 32'd6);
`endif

      fill_mem(PAT_WINDOW);
      run_pool(100, 1'b1, "window");
      sweep(PAT_WINDOW, "window_read");
      pool_read_addr = 32'd4095;
      @(posedge clk); #1;
`ifdef POOL_AVG_EN
      check("window_addr4095", 32'(pool_read_data), 32'hB);
`else
      check("window_addr4095", 32'(pool_read_data), 32'hF);
`endif

      fill_mem(PAT_RAMP);
      run_with_reset(3000);
      run_pool(0, 1'b0, "after_reset");
      sweep(PAT_RAMP, "after_reset_read");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
